mq_scoreboard: RTL

- Synthesisable-style reference model and checker for multi-port, multi-queue linked-list memories (1kNl family).
- Sits beside the DUT in the bench and snoops the same push/pop ports; keeps a per-queue FIFO model and a shared free-cell count.
- Checks every pop response after a fixed latency, plus the DUT free count; reports sticky, counted and first-error diagnostics.
- Generalises the single-port fixed driver/checker to NUMPUPT push and NUMPOPT pop ports, with configurable latency and check modes.

---
 rtl/mq_scoreboard_pkg.sv | 26 ++
 rtl/mq_sb_lat_pipe.sv | 27 ++
 rtl/mq_scoreboard.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mq_scoreboard_pkg.sv
// Shared types and helpers for the multi-queue linked-list scoreboard.
package mq_scoreboard_pkg;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_DATA = 3'd1,
        ERR_SPUR = 3'd2,
        ERR_MISS = 3'd3,
        ERR_FREE = 3'd4,
        ERR_PUSH = 3'd5,
        ERR_POP  = 3'd6
    } err_code_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Packed width of a latency-pipe entry {vld, queue, data}.
    function automatic int unsigned pipe_ent_bits(input int unsigned bitqueu, input int unsigned width);
        return 1 + bitqueu + width;
    endfunction

endpackage

// File: rtl/mq_sb_lat_pipe.sv
// Fixed-depth shift register carrying expected pop responses to the compare point.
module mq_sb_lat_pipe #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned W       = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ent_i,
    output logic [W-1:0] ent_o
);

    logic [W-1:0] stg_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q <= '{default: '0};
        end else begin
            stg_q[0] <= ent_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign ent_o = stg_q[LATENCY-1];

endmodule

// File: rtl/mq_scoreboard.sv
// Reference model and checker snooping the push/pop ports of a multi-queue
// shared-cell memory; reports sticky, counted and first-error diagnostics.
module mq_scoreboard
    import mq_scoreboard_pkg::*;
#(
    parameter int unsigned NUMPUPT = 2,
    parameter int unsigned NUMPOPT = 2,
    parameter int unsigned NUMQUEU = 64,
    parameter int unsigned BITQUEU = 6,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned BITQCNT = 6,
    parameter int unsigned NUMCELL = 48,
    parameter int unsigned BITFCNT = 6,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CHKFREE = 1,
    parameter int unsigned STRICT  = 1,
    parameter int unsigned BITECNT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMPUPT-1:0]         push,
    input  logic [NUMPUPT*BITQUEU-1:0] pu_adr,
    input  logic [NUMPUPT*WIDTH-1:0]   pu_din,
    input  logic [NUMPOPT-1:0]         pop,
    input  logic [NUMPOPT*BITQUEU-1:0] po_adr,
    input  logic [NUMPOPT-1:0]         po_dvld,
    input  logic [NUMPOPT*WIDTH-1:0]   po_dout,
    input  logic [BITFCNT-1:0]         freecnt,
    input  logic [BITQUEU-1:0]         qry_adr,
    output logic [BITQCNT-1:0]         qry_cnt,
    output logic [BITFCNT-1:0]         mdl_freecnt,
    output logic                       err,
    output logic [BITECNT-1:0]         err_cnt,
    output logic [2:0]                 err_code,
    output logic [2:0]                 err_port,
    output logic [BITQUEU-1:0]         err_queue,
    output logic [WIDTH-1:0]           err_exp,
    output logic [WIDTH-1:0]           err_act
);

    localparam int unsigned BITPTR = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int unsigned PEW    = pipe_ent_bits(BITQUEU, WIDTH);
    localparam logic [BITPTR-1:0]  PTR_LAST = BITPTR'(DEPTH - 1);
    localparam logic [BITQCNT-1:0] DEPTH_C  = BITQCNT'(DEPTH);
    localparam logic [BITFCNT-1:0] FREE_RST = BITFCNT'(NUMCELL);

    typedef struct packed {
        logic               vld;
        logic [BITQUEU-1:0] queue;
        logic [WIDTH-1:0]   data;
    } pipe_ent_t;

    logic [BITQCNT-1:0] cnt_q [NUMQUEU];
    logic [BITQCNT-1:0] cnt_d [NUMQUEU];
    logic [BITPTR-1:0]  rdp_q [NUMQUEU];
    logic [BITPTR-1:0]  rdp_d [NUMQUEU];
    logic [BITPTR-1:0]  wrp_q [NUMQUEU];
    logic [BITPTR-1:0]  wrp_d [NUMQUEU];
    logic [WIDTH-1:0]   mem_q [NUMQUEU][DEPTH];
    logic [BITFCNT-1:0] free_q, free_d, free_dly_q;

    logic [NUMPUPT-1:0] wr_en, push_rej;
    logic [BITQUEU-1:0] wr_qi [NUMPUPT];
    logic [BITPTR-1:0]  wr_pi [NUMPUPT];
    logic [NUMPOPT-1:0] pop_rej;
    pipe_ent_t          pop_ent  [NUMPOPT];
    pipe_ent_t          pipe_out [NUMPOPT];
    logic [BITQUEU-1:0] pq, qi;

    function automatic logic [BITPTR-1:0] ptr_inc(input logic [BITPTR-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Running state: pops in port order first, then pushes, so a pop's freed cell
    // is visible to a same-cycle push but a same-cycle push is never poppable.
    always_comb begin
        cnt_d    = cnt_q;
        rdp_d    = rdp_q;
        wrp_d    = wrp_q;
        free_d   = free_q;
        pq       = '0;
        qi       = '0;
        pop_rej  = '0;
        push_rej = '0;
        wr_en    = '0;
        for (int unsigned p = 0; p < NUMPOPT; p++) begin
            pop_ent[p] = '0;
            pq = po_adr[p*BITQUEU +: BITQUEU];
            if (pop[p] === 1'b1) begin
                if (cnt_d[pq] != '0) begin
                    pop_ent[p].vld   = 1'b1;
                    pop_ent[p].queue = pq;
                    pop_ent[p].data  = mem_q[pq][rdp_d[pq]];
                    rdp_d[pq] = ptr_inc(rdp_d[pq]);
                    cnt_d[pq] = cnt_d[pq] - 1'b1;
                    free_d    = free_d + 1'b1;
                end else begin
                    pop_rej[p] = 1'b1;
                end
            end
        end
        for (int unsigned p = 0; p < NUMPUPT; p++) begin
            qi = pu_adr[p*BITQUEU +: BITQUEU];
            wr_qi[p] = qi;
            wr_pi[p] = wrp_d[qi];
            if (push[p] === 1'b1) begin
                if ((cnt_d[qi] < DEPTH_C) && (free_d != '0)) begin
                    wr_en[p]  = 1'b1;
                    wrp_d[qi] = ptr_inc(wrp_d[qi]);
                    cnt_d[qi] = cnt_d[qi] + 1'b1;
                    free_d    = free_d - 1'b1;
                end else begin
                    push_rej[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUMPUPT; p++) begin
            if (wr_en[p]) mem_q[wr_qi[p]][wr_pi[p]] <= pu_din[p*WIDTH +: WIDTH];
        end
    end

    for (genvar gp = 0; gp < NUMPOPT; gp++) begin : g_pipe
        mq_sb_lat_pipe #(.LATENCY(LATENCY), .W(PEW)) u_pipe (
            .clk   (clk),
            .rst   (rst),
            .ent_i (pop_ent[gp]),
            .ent_o (pipe_out[gp])
        );
    end

    logic [NUMPOPT-1:0] e_data, e_spur, e_miss, e_pop;
    logic [NUMPUPT-1:0] e_push;
    logic               e_free, dv;

    always_comb begin
        e_data = '0;
        e_spur = '0;
        e_miss = '0;
        dv     = 1'b0;
        for (int unsigned p = 0; p < NUMPOPT; p++) begin
            dv = (po_dvld[p] === 1'b1);
            e_data[p] = pipe_out[p].vld & dv & (po_dout[p*WIDTH +: WIDTH] !== pipe_out[p].data);
            e_spur[p] = ~pipe_out[p].vld & dv;
            e_miss[p] = pipe_out[p].vld & ~dv;
        end
    end

    assign e_free = (CHKFREE != 0) && (freecnt !== free_dly_q);
    assign e_push = (STRICT != 0) ? push_rej : '0;
    assign e_pop  = (STRICT != 0) ? pop_rej  : '0;

    logic [BITECNT:0]   ev_n, ev_sum;
    logic [BITECNT-1:0] err_cnt_q, err_cnt_d;
    logic               found_d, err_q;
    err_code_e          code_d, err_code_q;
    logic [2:0]         port_d, err_port_q;
    logic [BITQUEU-1:0] queue_d, err_queue_q;
    logic [WIDTH-1:0]   exp_d, act_d, err_exp_q, err_act_q;

    // Scanning codes in ascending order, ports ascending within each, makes the
    // first hit the lowest code/lowest port of the cycle.
    always_comb begin
        ev_n = '0; found_d = 1'b0; code_d = ERR_NONE;
        port_d = '0; queue_d = '0; exp_d = '0; act_d = '0;
        for (int unsigned p = 0; p < NUMPOPT; p++) begin
            if (e_data[p]) begin
                ev_n = ev_n + 1'b1;
                if (!found_d) begin
                    found_d = 1'b1; code_d = ERR_DATA; port_d = 3'(p); queue_d = pipe_out[p].queue;
                    exp_d = pipe_out[p].data; act_d = po_dout[p*WIDTH +: WIDTH];
                end
            end
        end
        for (int unsigned p = 0; p < NUMPOPT; p++) begin
            if (e_spur[p]) begin
                ev_n = ev_n + 1'b1;
                if (!found_d) begin
                    found_d = 1'b1; code_d = ERR_SPUR; port_d = 3'(p); act_d = po_dout[p*WIDTH +: WIDTH];
                end
            end
        end
        for (int unsigned p = 0; p < NUMPOPT; p++) begin
            if (e_miss[p]) begin
                ev_n = ev_n + 1'b1;
                if (!found_d) begin
                    found_d = 1'b1; code_d = ERR_MISS; port_d = 3'(p); queue_d = pipe_out[p].queue;
                    exp_d = pipe_out[p].data;
                end
            end
        end
        if (e_free) begin
            ev_n = ev_n + 1'b1;
            if (!found_d) begin
                found_d = 1'b1; code_d = ERR_FREE;
            end
        end
        for (int unsigned p = 0; p < NUMPUPT; p++) begin
            if (e_push[p]) begin
                ev_n = ev_n + 1'b1;
                if (!found_d) begin
                    found_d = 1'b1; code_d = ERR_PUSH; port_d = 3'(p);
                    queue_d = pu_adr[p*BITQUEU +: BITQUEU]; act_d = pu_din[p*WIDTH +: WIDTH];
                end
            end
        end
        for (int unsigned p = 0; p < NUMPOPT; p++) begin
            if (e_pop[p]) begin
                ev_n = ev_n + 1'b1;
                if (!found_d) begin
                    found_d = 1'b1; code_d = ERR_POP; port_d = 3'(p);
                    queue_d = po_adr[p*BITQUEU +: BITQUEU];
                end
            end
        end
        ev_sum    = {1'b0, err_cnt_q} + ev_n;
        err_cnt_d = ev_sum[BITECNT] ? '1 : ev_sum[BITECNT-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '{default: '0};
            rdp_q       <= '{default: '0};
            wrp_q       <= '{default: '0};
            free_q      <= FREE_RST;
            free_dly_q  <= FREE_RST;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            err_code_q  <= ERR_NONE;
            err_port_q  <= '0;
            err_queue_q <= '0;
            err_exp_q   <= '0;
            err_act_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rdp_q      <= rdp_d;
            wrp_q      <= wrp_d;
            free_q     <= free_d;
            free_dly_q <= free_q;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_q | found_d;
            if (found_d && !err_q) begin
                err_code_q  <= code_d;
                err_port_q  <= port_d;
                err_queue_q <= queue_d;
                err_exp_q   <= exp_d;
                err_act_q   <= act_d;
            end
        end
    end

    assign qry_cnt     = cnt_q[qry_adr];
    assign mdl_freecnt = free_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
    assign err_code    = err_code_q;
    assign err_port    = err_port_q;
    assign err_queue   = err_queue_q;
    assign err_exp     = err_exp_q;
    assign err_act     = err_act_q;

endmodule
